// File: rtl/imm_ext_pipe.sv
// Immediate extender (zero/sign/shifted/upper-load) behind a two-entry output skid buffer.
// Define IMM_EXT_OVF_EN to add the out_ovf shift-overflow flag.
module imm_ext_pipe #(
    parameter int unsigned IN_W  = 12,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
`ifdef IMM_EXT_OVF_EN
    output logic             out_ovf,
`endif
    output logic [15:0]      xfer_cnt
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PAD_W  = OUT_W - IN_W;
    localparam int unsigned TOP_SH = OUT_W - 1 - SHIFT;

    localparam logic [1:0] MODE_ZERO  = 2'd0;
    localparam logic [1:0] MODE_SEXT  = 2'd1;
    localparam logic [1:0] MODE_SHL   = 2'd2;
    localparam logic [1:0] MODE_UPPER = 2'd3;

    logic signed [OUT_W-1:0] sext_c;
    logic [OUT_W-1:0]        res_c;
    logic                    in_xfer_c;
    logic                    out_xfer_c;
    logic                    out_load_c;

    logic                    skid_full;
    logic [OUT_W-1:0]        skid_data;

    logic                    out_valid_nxt;
    logic [OUT_W-1:0]        out_data_nxt;
    logic                    skid_full_nxt;
    logic [OUT_W-1:0]        skid_data_nxt;
    logic [CNT_W-1:0]        cnt_nxt;

`ifdef IMM_EXT_OVF_EN
    logic signed [OUT_W-1:0] top_c;
    logic                    res_ovf_c;
    logic                    skid_ovf;
    logic                    out_ovf_nxt;
    logic                    skid_ovf_nxt;
`endif

    // Extension datapath, evaluated on the offered immediate
    always_comb begin
        sext_c = OUT_W'($signed(in_imm));
        res_c  = OUT_W'(in_imm);
        case (in_mode)
            MODE_ZERO:  res_c = OUT_W'(in_imm);
            MODE_SEXT:  res_c = sext_c;
            MODE_SHL:   res_c = sext_c << SHIFT;
            MODE_UPPER: res_c = OUT_W'(in_imm) << PAD_W;
            default:    res_c = OUT_W'(in_imm);
        endcase
`ifdef IMM_EXT_OVF_EN
        // Bits shifted out must all equal the new sign bit, else the value changed
        top_c     = sext_c >>> TOP_SH;
        res_ovf_c = (in_mode == MODE_SHL) && (top_c != '0) && (top_c != '1);
`endif
    end

    // Output/skid routing; skid only fills while the output register is stalled
    always_comb begin
        in_xfer_c     = in_valid && in_ready;
        out_xfer_c    = out_valid && out_ready;
        out_load_c    = !out_valid || out_ready;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        skid_full_nxt = skid_full;
        skid_data_nxt = skid_data;
        cnt_nxt       = out_xfer_c ? xfer_cnt + CNT_W'(1) : xfer_cnt;
`ifdef IMM_EXT_OVF_EN
        out_ovf_nxt   = out_ovf;
        skid_ovf_nxt  = skid_ovf;
`endif
        if (out_load_c) begin
            if (skid_full) begin
                out_valid_nxt = 1'b1;
                out_data_nxt  = skid_data;
                skid_full_nxt = 1'b0;
`ifdef IMM_EXT_OVF_EN
                out_ovf_nxt   = skid_ovf;
`endif
            end else if (in_xfer_c) begin
                out_valid_nxt = 1'b1;
                out_data_nxt  = res_c;
`ifdef IMM_EXT_OVF_EN
                out_ovf_nxt   = res_ovf_c;
`endif
            end else begin
                out_valid_nxt = 1'b0;
            end
        end else if (in_xfer_c) begin
            skid_full_nxt = 1'b1;
            skid_data_nxt = res_c;
`ifdef IMM_EXT_OVF_EN
            skid_ovf_nxt  = res_ovf_c;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_full <= 1'b0;
            skid_data <= '0;
            in_ready  <= 1'b1;
            xfer_cnt  <= '0;
`ifdef IMM_EXT_OVF_EN
            out_ovf   <= 1'b0;
            skid_ovf  <= 1'b0;
`endif
        end else begin
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            skid_full <= skid_full_nxt;
            skid_data <= skid_data_nxt;
            in_ready  <= !skid_full_nxt;
            xfer_cnt  <= cnt_nxt;
`ifdef IMM_EXT_OVF_EN
            out_ovf   <= out_ovf_nxt;
            skid_ovf  <= skid_ovf_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: vector table, hand sequences, and a
// randomized scoreboard run against an arithmetic reference model.
module tb_imm_ext_pipe;

`ifdef IMM_EXT_OVF_EN
    localparam int unsigned IN_W  = 16;
    localparam int unsigned SHIFT = 2;
`else
    localparam int unsigned IN_W  = 12;
    localparam int unsigned SHIFT = 1;
`endif
    localparam int unsigned OUT_W = 16;
    localparam int unsigned NVEC  = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm = '0;
    logic [1:0]       in_mode = 2'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic [15:0]      xfer_cnt;
`ifdef IMM_EXT_OVF_EN
    logic             out_ovf;
`endif

    int checks = 0;
    int errors = 0;

    imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef IMM_EXT_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: integer arithmetic on the immediate's numeric value
    function automatic logic [OUT_W:0] ref_res(input logic [IN_W-1:0] imm, input logic [1:0] mode);
        longint m, u, s, v;
        logic   ovf;
        m   = longint'(1) << OUT_W;
        u   = longint'(imm);
        s   = imm[IN_W-1] ? u - (longint'(1) << IN_W) : u;
        ovf = 1'b0;
        case (mode)
            2'd0: v = u;
            2'd1: v = s;
            2'd2: begin
                v   = s * (longint'(1) << SHIFT);
                ovf = (v < -(m / 2)) || (v >= m / 2);
            end
            default: v = u * (longint'(1) << (OUT_W - IN_W));
        endcase
        v = ((v % m) + m) % m;
        return {ovf, OUT_W'(v)};
    endfunction

    // Scoreboard: queue of accepted results, checked on every output transfer
    logic [OUT_W:0]   exp_q[$];
    logic [15:0]      exp_cnt = '0;
    logic             hold_prev = 1'b0;
    logic [OUT_W:0]   hold_val = '0;

    always @(negedge clk) begin
        logic [OUT_W:0] e;
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt   = '0;
            hold_prev = 1'b0;
        end else begin
            chk("mon_out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            chk("mon_in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            chk("mon_xfer_cnt", 64'(xfer_cnt), 64'(exp_cnt));
            if (hold_prev) begin
                chk("mon_hold_data", 64'(out_data), 64'(hold_val[OUT_W-1:0]));
`ifdef IMM_EXT_OVF_EN
                chk("mon_hold_ovf", 64'(out_ovf), 64'(hold_val[OUT_W]));
`endif
            end
            hold_prev = out_valid && !out_ready;
`ifdef IMM_EXT_OVF_EN
            hold_val  = {out_ovf, out_data};
`else
            hold_val  = {1'b0, out_data};
`endif
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_spurious_out actual=%0h expected=none at %0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_data", 64'(out_data), 64'(e[OUT_W-1:0]));
`ifdef IMM_EXT_OVF_EN
                    chk("mon_ovf", 64'(out_ovf), 64'(e[OUT_W]));
`endif
                end
                exp_cnt = exp_cnt + 16'd1;
            end
            if (in_valid && in_ready)
                exp_q.push_back(ref_res(in_imm, in_mode));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_xfer_cnt", 64'(xfer_cnt), 64'(0));
`ifdef IMM_EXT_OVF_EN
        chk("rst_out_ovf", 64'(out_ovf), 64'(0));
`endif
    endtask

    typedef struct {
        logic [IN_W-1:0]  imm;
        logic [1:0]       mode;
        logic [OUT_W-1:0] data;
        logic             ovf;
    } vec_t;

    vec_t vecs[NVEC];

    initial begin
        #1_500_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef IMM_EXT_OVF_EN
        vecs[0] = '{IN_W'(16'h4000), 2'd2, 16'h0000, 1'b1};
        vecs[1] = '{IN_W'(16'h1000), 2'd2, 16'h4000, 1'b0};
        vecs[2] = '{IN_W'(16'hE000), 2'd2, 16'h8000, 1'b0};
        vecs[3] = '{IN_W'(16'h2000), 2'd2, 16'h8000, 1'b1};
        vecs[4] = '{IN_W'(16'hC000), 2'd2, 16'h0000, 1'b1};
        vecs[5] = '{IN_W'(16'h8000), 2'd1, 16'h8000, 1'b0};
        vecs[6] = '{IN_W'(16'h1234), 2'd0, 16'h1234, 1'b0};
        vecs[7] = '{IN_W'(16'hABCD), 2'd3, 16'hABCD, 1'b0};
`else
        vecs[0] = '{IN_W'(12'h800), 2'd0, 16'h0800, 1'b0};
        vecs[1] = '{IN_W'(12'h800), 2'd1, 16'hF800, 1'b0};
        vecs[2] = '{IN_W'(12'h7FF), 2'd2, 16'h0FFE, 1'b0};
        vecs[3] = '{IN_W'(12'hABC), 2'd3, 16'hABC0, 1'b0};
        vecs[4] = '{IN_W'(12'h7FF), 2'd1, 16'h07FF, 1'b0};
        vecs[5] = '{IN_W'(12'h800), 2'd2, 16'hF000, 1'b0};
        vecs[6] = '{IN_W'(12'hFFF), 2'd0, 16'h0FFF, 1'b0};
        vecs[7] = '{IN_W'(12'h001), 2'd3, 16'h0010, 1'b0};
`endif

        // Mode table: each result one cycle after acceptance
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < int'(NVEC); i++) begin
            in_valid = 1'b1;
            in_imm   = vecs[i].imm;
            in_mode  = vecs[i].mode;
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
            chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].data));
`ifdef IMM_EXT_OVF_EN
            chk($sformatf("vec%0d_ovf", i), 64'(out_ovf), 64'(vecs[i].ovf));
`endif
            step();
        end

        // Backpressure: third offer stalls, then all drain in order
        do_reset();
        out_ready = 1'b0;
        in_mode   = 2'd1;
        in_valid  = 1'b1;
        in_imm    = IN_W'(1);
        step();
        chk("bp_ready_after_1", 64'(in_ready), 64'(1));
        chk("bp_data_1", 64'(out_data), 64'(1));
        in_imm = IN_W'(2);
        step();
        chk("bp_ready_after_2", 64'(in_ready), 64'(0));
        in_imm = IN_W'(3);
        repeat (3) step();
        chk("bp_ready_held", 64'(in_ready), 64'(0));
        chk("bp_data_held", 64'(out_data), 64'(1));
        out_ready = 1'b1;
        step();
        chk("bp_drain_2", 64'(out_data), 64'(2));
        chk("bp_ready_reopen", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        chk("bp_drain_3", 64'(out_data), 64'(3));
        step();
        chk("bp_empty", 64'(out_valid), 64'(0));
        chk("bp_xfer_cnt", 64'(xfer_cnt), 64'(3));

        // Streaming: one result per cycle with in_ready held high
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_imm   = IN_W'($urandom);
            in_mode  = 2'($urandom_range(0, 3));
            step();
            chk("stream_ready", 64'(in_ready), 64'(1));
            chk("stream_valid", 64'(out_valid), 64'(1));
        end
        in_valid = 1'b0;
        step();
        chk("stream_xfer_cnt", 64'(xfer_cnt), 64'(10));

        // Reset with both registers full: held results vanish
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd0;
        in_imm    = IN_W'(12'h055);
        step();
        in_imm = IN_W'(12'h0AA);
        step();
        in_valid = 1'b0;
        chk("midrst_full", 64'(in_ready), 64'(0));
        do_reset();
        out_ready = 1'b1;
        repeat (3) step();
        chk("midrst_no_ghost", 64'(out_valid), 64'(0));
        chk("midrst_cnt", 64'(xfer_cnt), 64'(0));

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_imm    = IN_W'($urandom);
            in_mode   = 2'($urandom_range(0, 3));
            step();
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("rand_drained", 64'(out_valid), 64'(0));

        // Counter wrap after 65536 transfers
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_imm  = IN_W'($urandom);
            in_mode = 2'($urandom_range(0, 3));
            step();
        end
        in_valid = 1'b0;
        step();
        chk("wrap_ffff", 64'(xfer_cnt), 64'(16'hFFFF));
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("wrap_zero", 64'(xfer_cnt), 64'(16'h0000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter: IN_W, 12, width of the immediate field presented on in_imm; legal range 1..OUT_W.
REQ-002 Parameter: OUT_W, 16, datapath word width of out_data.
REQ-003 Parameter: SHIFT, 1, left-shift amount applied in mode 2; legal range 0..OUT_W-1.
REQ-004 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-006 Port: in_valid  input  1  upstream offers an immediate this cycle.
REQ-007 Port: in_ready  output  1  block accepts when high; driven directly from a flop.
REQ-008 Port: in_imm  input  IN_W  raw immediate field.
REQ-009 Port: in_mode  input  2  0 zero-ext, 1 sign-ext, 2 sign-ext then shift left by SHIFT, 3 upper-load.
REQ-010 Port: out_valid  output  1  out_data holds a result.
REQ-011 Port: out_ready  input  1  downstream accepts when high.
REQ-012 Port: out_data  output  OUT_W  extended result.
REQ-013 Port: out_ovf  output  1  overflow flag for the result on out_data; present only with IMM_EXT_OVF_EN.
REQ-014 Port: xfer_cnt  output  16  count of completed output transfers.

Function
REQ-015 Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-016 Mode 0: out = {zeros, in_imm}.
REQ-017 Mode 1: out = {(OUT_W-IN_W) copies of in_imm[IN_W-1], in_imm}.
REQ-018 Mode 2: out = mode-1 value shifted left by SHIFT, truncated to OUT_W bits, zeros shifted in.
REQ-019 Mode 3: out = in_imm placed in bits [OUT_W-1:OUT_W-IN_W], lower bits zero.
REQ-020 When IN_W == OUT_W: modes 0 and 1 pass in_imm unchanged.
REQ-021 Storage: one output register plus one skid register; the result is computed combinationally from in_imm/in_mode and captured at the input transfer.
REQ-022 Latency: a result accepted at edge N appears on out_data with out_valid=1 after edge N when the output register is empty or transferring at edge N.
REQ-023 Routing: if the output register is empty or transferring, the accepted result loads the output register; otherwise it loads the skid register.
REQ-024 Skid drain: on an output transfer with the skid register full, the skid contents move to the output register on the same edge.
REQ-025 in_ready is the registered value of !skid_full and deasserts on the edge the skid register fills.
REQ-026 Simultaneous input and output transfer with the skid register empty: the output register takes the new result and out_valid stays 1.
REQ-027 Ordering: results leave strictly in acceptance order; none is dropped or duplicated.
REQ-028 out_data and out_ovf remain stable while out_valid=1 and out_ready=0.
REQ-029 xfer_cnt increments by 1 on each output transfer and wraps from 0xFFFF to 0x0000.

Reset
REQ-030 While rst_n=0 at a rising edge: out_valid=0, skid empty, in_ready=1, out_data=0, out_ovf=0, xfer_cnt=0.
REQ-031 A reset asserted mid-operation discards both held results; no output transfer is reported for them.
REQ-032 The first input transfer is possible on the first edge after rst_n returns high.

Configuration
REQ-033 With IMM_EXT_OVF_EN defined, out_ovf is present and is computed at capture and held per entry.
REQ-034 out_ovf = 1 only in mode 2, when the top SHIFT+1 bits of the mode-1 value are not all equal; otherwise out_ovf = 0.
REQ-035 Without IMM_EXT_OVF_EN, out_ovf is absent and no overflow logic is present; all other behaviour is identical.

Verification (default parameters unless stated)
REQ-036 Mode sweep with out_ready=1: 0x800/m0 -> 0x0800; 0x800/m1 -> 0xF800; 0x7FF/m2 -> 0x0FFE; 0xABC/m3 -> 0xABC0, each one cycle after acceptance.
REQ-037 Backpressure: out_ready=0, drive 0x001, 0x002, 0x003 (m1) back-to-back -> first two accepted, in_ready=0 from the second accept, 0x003 held; raise out_ready -> 0x0001, 0x0002, 0x0003 in order; xfer_cnt=3.
REQ-038 Streaming: in_valid=out_ready=1 for 10 cycles -> one result per cycle, in_ready stays 1, xfer_cnt=10.
REQ-039 Reset mid-stream: both registers full, rst_n=0 for one edge -> out_valid=0, in_ready=1, xfer_cnt=0; the held results never appear.
REQ-040 IMM_EXT_OVF_EN with IN_W=16, SHIFT=2: 0x4000/m2 -> out_data 0x0000, out_ovf=1; 0x1000/m2 -> out_data 0x4000, out_ovf=0.
REQ-041 Wrap: preload by running 65535 transfers, then one more -> xfer_cnt reads 0x0000.
